// File: rtl/loop_index_pkg.sv
// Shared state encoding and default datapath width for the loop-index sequencer.
package loop_index_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REF = 3'd1,
    CLR_I  = 3'd2,
    CHECK  = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/loop_index_ctrl.sv
// Loop-index sequencer: owns every Reg_X I/Iref write strobe for counted loops.
// Define LOOP_INDEX_CTRL_SHADOW_CHECK_EN to build the iflag-vs-shadow comparator.
module loop_index_ctrl
  import loop_index_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CHECK_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             step,
  input  logic             abort,
  input  logic             iflag,
  output logic             write_i,
  output logic             write_iref,
  output logic             read_i,
  output logic             read_iref,
  output logic [WIDTH-1:0] reg_data,
  output logic             busy,
  output logic             step_ack,
  output logic             loop_done,
  output logic [WIDTH-1:0] iter,
  output logic             err
);

  localparam int unsigned CNT_W = 3;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] iter_d, reg_data_d;
  logic             write_i_d, write_iref_d, read_i_d, busy_d;
  logic             step_ack_d, loop_done_d, err_d, step_take;

  // Iref is never driven back onto the bus by this sequencer.
  assign read_iref = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      limit_q    <= '0;
      iter       <= '0;
      reg_data   <= '0;
      write_i    <= 1'b0;
      write_iref <= 1'b0;
      read_i     <= 1'b0;
      busy       <= 1'b0;
      step_ack   <= 1'b0;
      loop_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      iter       <= iter_d;
      reg_data   <= reg_data_d;
      write_i    <= write_i_d;
      write_iref <= write_iref_d;
      read_i     <= read_i_d;
      busy       <= busy_d;
      step_ack   <= step_ack_d;
      loop_done  <= loop_done_d;
      err        <= err_d;
    end
  end

  // Next state, then outputs registered from the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    limit_d      = limit_q;
    iter_d       = iter;
    reg_data_d   = '0;
    write_i_d    = 1'b0;
    write_iref_d = 1'b0;
    read_i_d     = 1'b0;
    busy_d       = 1'b0;
    step_ack_d   = 1'b0;
    loop_done_d  = 1'b0;
    step_take    = 1'b0;
`ifdef LOOP_INDEX_CTRL_SHADOW_CHECK_EN
    err_d        = err;
`else
    err_d        = 1'b0;
`endif

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            limit_d = limit;
            state_d = LD_REF;
          end
        end
        LD_REF: state_d = CLR_I;
        CLR_I: begin
          cnt_d   = CNT_W'(CHECK_LAT);
          state_d = CHECK;
        end
        CHECK: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = iflag ? DONE : RUN;
`ifdef LOOP_INDEX_CTRL_SHADOW_CHECK_EN
            if (iflag != (iter == limit_q)) err_d = 1'b1;
`endif
          end
        end
        RUN: begin
          // The increment write lands in the first CHECK cycle, so wait one extra.
          if (step) begin
            step_take = 1'b1;
            cnt_d     = CNT_W'(CHECK_LAT + 1);
            state_d   = CHECK;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    write_iref_d = (state_d == LD_REF);
    write_i_d    = (state_d == CLR_I) || step_take;
    read_i_d     = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    loop_done_d  = (state_d == DONE);
    step_ack_d   = step_take;
    if (state_d == LD_REF) reg_data_d = limit_d;
    if (state_d == CLR_I)  iter_d     = '0;
    if (step_take) begin
      iter_d     = iter + WIDTH'(1);
      reg_data_d = iter + WIDTH'(1);
    end
  end

endmodule
